// File: rtl/mawg_multichannel.sv
// Multi-channel waveform generator: per-channel phase accumulators (saw/tri/pulse/chirp)
// with double-buffered config committed on phase wrap, plus a registered channel/sum mux.
module mawg_multichannel #(
  parameter int CHANNELS = 2,
  parameter int PHASE_W  = 32,
  parameter int OUT_W    = 16,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [2:0]          cfg_addr,
  input  logic [PHASE_W-1:0]  cfg_wdata,
  input  logic                cfg_commit,
  input  logic [CH_W:0]       out_sel,
  output logic [CHANNELS-1:0] pending,
  output logic [CHANNELS-1:0] ch_wrap,
  output logic [OUT_W-1:0]    signal
);

  localparam int SUM_W = OUT_W + CH_W + 1;
  localparam logic [OUT_W-1:0] SIGN_BIT = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(-(1 << (OUT_W-1)));

  typedef struct packed {
    logic [3:0]         mode;
    logic [PHASE_W-1:0] freq;
    logic [PHASE_W-1:0] duty;
    logic [PHASE_W-1:0] cmin;
    logic [PHASE_W-1:0] cmax;
    logic [PHASE_W-1:0] cinc;
    logic [PHASE_W-1:0] cdiv;
  } cfg_t;

  logic [OUT_W-1:0] samp [CHANNELS];

  genvar g;
  for (g = 0; g < CHANNELS; g++) begin : g_ch
    cfg_t               sh_q, sh_d, act_q, act_d;
    logic [PHASE_W-1:0] acc_q, acc_d, cur_q, cur_d, dcnt_q, dcnt_d;
    logic               pend_q, pend_d, wrap_q, wrap_d;
    logic               en, is_chirp, sel_hit, xfer;
    logic [PHASE_W-1:0] inc;
    logic [PHASE_W:0]   acc_sum, up_sum, dn_diff;
    logic [OUT_W-1:0]   t_w, tri_w;

    assign sel_hit  = (cfg_ch == CH_W'(g));
    assign en       = act_q.mode[3];
    assign is_chirp = (act_q.mode[1:0] == 2'd3);
    assign inc      = is_chirp ? cur_q : act_q.freq;
    assign acc_sum  = {1'b0, acc_q} + {1'b0, inc};
    assign up_sum   = {1'b0, cur_q} + {1'b0, act_q.cinc};
    assign dn_diff  = {1'b0, cur_q} - {1'b0, act_q.cinc};
    // A disabled channel never wraps, so it accepts a pending commit on the next cycle.
    assign xfer     = pend_q & (~en | acc_sum[PHASE_W]);

    always_comb begin
      sh_d   = sh_q;
      act_d  = act_q;
      acc_d  = acc_q;
      cur_d  = cur_q;
      dcnt_d = dcnt_q;
      pend_d = pend_q;
      wrap_d = 1'b0;
      if (en) begin
        acc_d  = acc_sum[PHASE_W-1:0];
        wrap_d = acc_sum[PHASE_W];
      end
      if (en && is_chirp) begin
        if (dcnt_q == act_q.cdiv) begin
          dcnt_d = '0;
          if (act_q.mode[2]) begin
            cur_d = (dn_diff[PHASE_W] || (dn_diff[PHASE_W-1:0] < act_q.cmin)) ?
                    act_q.cmax : dn_diff[PHASE_W-1:0];
          end else begin
            cur_d = (up_sum > {1'b0, act_q.cmax}) ? act_q.cmin : up_sum[PHASE_W-1:0];
          end
        end else begin
          dcnt_d = dcnt_q + PHASE_W'(1);
        end
      end
      // Transfer uses the shadow as it stood before any same-cycle write.
      if (xfer) begin
        act_d  = sh_q;
        cur_d  = sh_q.mode[2] ? sh_q.cmax : sh_q.cmin;
        dcnt_d = '0;
        pend_d = 1'b0;
      end else if (cfg_commit && sel_hit) begin
        pend_d = 1'b1;
      end
      if (cfg_we && sel_hit) begin
        case (cfg_addr)
          3'd0:    sh_d.mode = cfg_wdata[3:0];
          3'd1:    sh_d.freq = cfg_wdata;
          3'd2:    sh_d.duty = cfg_wdata;
          3'd3:    sh_d.cmin = cfg_wdata;
          3'd4:    sh_d.cmax = cfg_wdata;
          3'd5:    sh_d.cinc = cfg_wdata;
          3'd6:    sh_d.cdiv = cfg_wdata;
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sh_q   <= '0;
        act_q  <= '0;
        acc_q  <= '0;
        cur_q  <= '0;
        dcnt_q <= '0;
        pend_q <= 1'b0;
        wrap_q <= 1'b0;
      end else begin
        sh_q   <= sh_d;
        act_q  <= act_d;
        acc_q  <= acc_d;
        cur_q  <= cur_d;
        dcnt_q <= dcnt_d;
        pend_q <= pend_d;
        wrap_q <= wrap_d;
      end
    end

    assign t_w   = acc_q[PHASE_W-1 -: OUT_W];
    assign tri_w = acc_q[PHASE_W-1] ? ~acc_q[PHASE_W-2 -: OUT_W] : acc_q[PHASE_W-2 -: OUT_W];
    assign samp[g] = !en ? '0 :
                     (act_q.mode[1:0] == 2'd0) ? (t_w ^ SIGN_BIT) :
                     (act_q.mode[1:0] == 2'd2) ? ((acc_q < act_q.duty) ? ~SIGN_BIT : SIGN_BIT) :
                     (tri_w ^ SIGN_BIT);
    assign pending[g] = pend_q;
    assign ch_wrap[g] = wrap_q;
  end

  logic signed [SUM_W-1:0] sum_all;
  logic [OUT_W-1:0]        signal_q, signal_d;

  always_comb begin
    sum_all  = '0;
    signal_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sum_all = sum_all + {{(SUM_W-OUT_W){samp[i][OUT_W-1]}}, samp[i]};
    end
    if (out_sel == (CH_W+1)'(CHANNELS)) begin
      if (sum_all > SAT_HI)      signal_d = ~SIGN_BIT;
      else if (sum_all < SAT_LO) signal_d = SIGN_BIT;
      else                       signal_d = sum_all[OUT_W-1:0];
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (out_sel == (CH_W+1)'(i)) signal_d = samp[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) signal_q <= '0;
    else     signal_q <= signal_d;
  end

  assign signal = signal_q;

endmodule

// File: tb/tb_mawg_multichannel.sv
// Bench for mawg_multichannel: directed scenarios plus randomized traffic,
// all checked against an arithmetic reference model of the generator.
module tb_mawg_multichannel;
  localparam int CH  = 2;
  localparam int PW  = 32;
  localparam int OW  = 16;
  localparam int CHW = 1;
  localparam longint TWO32 = 64'h1_0000_0000;
  localparam longint TWO31 = 64'h8000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [CHW-1:0] cfg_ch = '0;
  logic [2:0]    cfg_addr = '0;
  logic [PW-1:0] cfg_wdata = '0;
  logic          cfg_commit = 1'b0;
  logic [CHW:0]  out_sel = '0;
  logic [CH-1:0] pending, ch_wrap;
  logic [OW-1:0] signal;

  int checks = 0;
  int failures = 0;

  mawg_multichannel #(.CHANNELS(CH), .PHASE_W(PW), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .out_sel(out_sel),
    .pending(pending), .ch_wrap(ch_wrap), .signal(signal)
  );

  always #5 clk = ~clk;

  // Reference model: register files indexed by cfg address (0 mode .. 6 chirp_div).
  longint ms_f [CH][7];
  longint ma_f [CH][7];
  longint m_acc [CH];
  longint m_cur [CH];
  longint m_dcnt [CH];
  bit     m_pend [CH];
  bit     m_wrap [CH];
  logic [OW-1:0] m_sig;

  function automatic longint model_sample(int c);
    longint a, mode;
    a = m_acc[c];
    mode = ma_f[c][0];
    if ((mode & 8) == 0) return 0;
    case (mode & 3)
      0: return (a >> 16) - 32768;
      2: return (a < ma_f[c][2]) ? 32767 : -32768;
      default: return ((a < TWO31) ? (a >> 15) : ((TWO32 - 1 - a) >> 15)) - 32768;
    endcase
  endfunction

  function automatic logic [CH-1:0] pend_vec();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = m_pend[i];
    return r;
  endfunction

  function automatic logic [CH-1:0] wrap_vec();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = m_wrap[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < 7; k++) begin
        ms_f[c][k] = 0;
        ma_f[c][k] = 0;
      end
      m_acc[c] = 0; m_cur[c] = 0; m_dcnt[c] = 0; m_pend[c] = 0; m_wrap[c] = 0;
    end
    m_sig = '0;
  endtask

  task automatic model_step();
    longint tot, s, sel;
    if (rst) begin
      model_reset();
      return;
    end
    tot = 0;
    for (int c = 0; c < CH; c++) tot += model_sample(c);
    sel = longint'(out_sel);
    if (sel < CH) s = model_sample(int'(sel));
    else if (sel == CH) s = (tot > 32767) ? 32767 : ((tot < -32768) ? -32768 : tot);
    else s = 0;
    m_sig = s[15:0];
    for (int c = 0; c < CH; c++) begin
      longint mode, inc, nxt, t;
      bit en, chirp, xfer;
      mode  = ma_f[c][0];
      en    = (mode & 8) != 0;
      chirp = (mode & 3) == 3;
      inc   = chirp ? m_cur[c] : ma_f[c][1];
      nxt   = m_acc[c] + inc;
      m_wrap[c] = en && (nxt >= TWO32);
      xfer = m_pend[c] && (!en || (nxt >= TWO32));
      if (en) m_acc[c] = nxt % TWO32;
      if (en && chirp) begin
        if (m_dcnt[c] == ma_f[c][6]) begin
          m_dcnt[c] = 0;
          if ((mode & 4) != 0) begin
            t = m_cur[c] - ma_f[c][5];
            m_cur[c] = (t < ma_f[c][3]) ? ma_f[c][4] : t;
          end else begin
            t = m_cur[c] + ma_f[c][5];
            m_cur[c] = (t > ma_f[c][4]) ? ma_f[c][3] : t;
          end
        end else begin
          m_dcnt[c] = m_dcnt[c] + 1;
        end
      end
      if (xfer) begin
        for (int k = 0; k < 7; k++) ma_f[c][k] = ms_f[c][k];
        m_cur[c]  = ((ms_f[c][0] & 4) != 0) ? ms_f[c][4] : ms_f[c][3];
        m_dcnt[c] = 0;
        m_pend[c] = 0;
      end else if (cfg_commit && int'(cfg_ch) == c) begin
        m_pend[c] = 1;
      end
      if (cfg_we && int'(cfg_ch) == c && cfg_addr != 3'd7)
        ms_f[c][cfg_addr] = (cfg_addr == 3'd0) ? longint'(cfg_wdata & 32'hF) : longint'(cfg_wdata);
    end
  endtask

  // Drivers: inputs change 1 time unit after the edge; model follows each edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input int ch, input int addr, input logic [31:0] data);
    cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_addr = 3'(addr); cfg_wdata = data;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic commit(input int ch);
    cfg_commit = 1'b1; cfg_ch = CHW'(ch);
    cycle();
    cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    repeat (3) cycle();
    checks++; if (signal !== 16'h0) begin failures++; $display("FAIL reset_signal got=%h exp=0000", signal); end
    checks++; if (pending !== 2'b00) begin failures++; $display("FAIL reset_pending got=%b exp=00", pending); end
    checks++; if (ch_wrap !== 2'b00) begin failures++; $display("FAIL reset_wrap got=%b exp=00", ch_wrap); end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_saw();
    int wraps;
    logic [15:0] exp;
    out_sel = '0;
    wr(0, 0, 32'h8);
    wr(0, 1, 32'h1000_0000);
    commit(0);
    checks++; if (pending[0] !== 1'b1) begin failures++; $display("FAIL saw_pend_set got=%b exp=1", pending[0]); end
    cycle();
    checks++; if (pending[0] !== 1'b0) begin failures++; $display("FAIL saw_pend_clear got=%b exp=0", pending[0]); end
    wraps = 0;
    for (int k = 1; k <= 32; k++) begin
      cycle();
      exp = 16'h8000 + 16'(k - 1) * 16'h1000;
      checks++; if (signal !== exp) begin failures++; $display("FAIL saw_step k=%0d got=%h exp=%h", k, signal, exp); end
      checks++; if (signal !== m_sig) begin failures++; $display("FAIL saw_model k=%0d got=%h exp=%h", k, signal, m_sig); end
      checks++; if (ch_wrap !== wrap_vec()) begin failures++; $display("FAIL saw_wrap k=%0d got=%b exp=%b", k, ch_wrap, wrap_vec()); end
      if (ch_wrap[0]) wraps++;
    end
    checks++; if (wraps != 2) begin failures++; $display("FAIL saw_wrap_count got=%0d exp=2", wraps); end
  endtask

  task automatic test_glitch_free();
    logic [15:0] prev, d;
    bit seen_new, bad;
    repeat (3) cycle();
    wr(0, 1, 32'h2000_0000);
    commit(0);
    checks++; if (pending[0] !== 1'b1) begin failures++; $display("FAIL glitch_pend_set got=%b exp=1", pending[0]); end
    prev = signal;
    seen_new = 0;
    bad = 0;
    for (int k = 0; k < 24; k++) begin
      cycle();
      checks++; if (signal !== m_sig) begin failures++; $display("FAIL glitch_model k=%0d got=%h exp=%h", k, signal, m_sig); end
      checks++; if (pending !== pend_vec()) begin failures++; $display("FAIL glitch_pend k=%0d got=%b exp=%b", k, pending, pend_vec()); end
      d = signal - prev;
      if (d == 16'h2000) seen_new = 1;
      else if (d != 16'h1000 || seen_new) bad = 1;
      prev = signal;
    end
    checks++; if (bad || !seen_new) begin failures++; $display("FAIL glitch_steps got=bad:%0d new:%0d exp=bad:0 new:1", bad, seen_new); end
  endtask

  task automatic test_pulse();
    int hi, waited;
    wr(0, 0, 32'hA);
    wr(0, 1, 32'h1000_0000);
    wr(0, 2, 32'h4000_0000);
    commit(0);
    waited = 0;
    while (pending[0] && waited < 40) begin
      cycle();
      waited++;
      checks++; if (pending !== pend_vec()) begin failures++; $display("FAIL pulse_pend got=%b exp=%b", pending, pend_vec()); end
    end
    checks++; if (pending[0] !== 1'b0) begin failures++; $display("FAIL pulse_commit_timeout got=%b exp=0", pending[0]); end
    repeat (2) cycle();
    hi = 0;
    for (int k = 0; k < 32; k++) begin
      cycle();
      checks++; if (signal !== m_sig) begin failures++; $display("FAIL pulse_model k=%0d got=%h exp=%h", k, signal, m_sig); end
      checks++; if (signal !== 16'h7FFF && signal !== 16'h8000) begin failures++; $display("FAIL pulse_level k=%0d got=%h exp=7fff|8000", k, signal); end
      if (signal === 16'h7FFF) hi++;
    end
    checks++; if (hi != 8) begin failures++; $display("FAIL pulse_duty got=%0d exp=8", hi); end
  endtask

  task automatic test_chirp();
    logic [15:0] v [14];
    logic [15:0] d, exp;
    out_sel = 2'd1;
    wr(1, 3, 32'h0100_0000);
    wr(1, 4, 32'h0400_0000);
    wr(1, 5, 32'h0100_0000);
    wr(1, 6, 32'd2);
    wr(1, 0, 32'hB);
    commit(1);
    cycle();
    checks++; if (pending[1] !== 1'b0) begin failures++; $display("FAIL chirp_pend got=%b exp=0", pending[1]); end
    for (int k = 1; k <= 60; k++) begin
      cycle();
      checks++; if (signal !== m_sig) begin failures++; $display("FAIL chirp_model k=%0d got=%h exp=%h", k, signal, m_sig); end
      if (k <= 13) v[k] = signal;
    end
    for (int k = 1; k <= 12; k++) begin
      d = v[k+1] - v[k];
      exp = 16'(((k - 1) / 3 + 1) * 32'h200);
      checks++; if (d !== exp) begin failures++; $display("FAIL chirp_step k=%0d got=%h exp=%h", k, d, exp); end
    end
  endtask

  task automatic test_reset_midrun();
    out_sel = '0;
    wr(0, 1, 32'h3000_0000);
    commit(0);
    checks++; if (pending[0] !== 1'b1) begin failures++; $display("FAIL rstmid_pend_set got=%b exp=1", pending[0]); end
    #3 rst = 1'b1;
    #1;
    model_reset();
    checks++; if (signal !== 16'h0) begin failures++; $display("FAIL rstmid_signal got=%h exp=0000", signal); end
    checks++; if (pending !== 2'b00) begin failures++; $display("FAIL rstmid_pending got=%b exp=00", pending); end
    checks++; if (ch_wrap !== 2'b00) begin failures++; $display("FAIL rstmid_wrap got=%b exp=00", ch_wrap); end
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      checks++; if (pending !== 2'b00 || signal !== 16'h0) begin failures++; $display("FAIL rstmid_after k=%0d got=%b/%h exp=00/0000", k, pending, signal); end
      checks++; if (signal !== m_sig) begin failures++; $display("FAIL rstmid_model k=%0d got=%h exp=%h", k, signal, m_sig); end
    end
  endtask

  task automatic test_sum();
    int waited;
    for (int c = 0; c < CH; c++) begin
      wr(c, 0, 32'hA);
      wr(c, 1, 32'h1000_0000);
      wr(c, 2, 32'hFFFF_FFFF);
    end
    commit(0);
    commit(1);
    out_sel = 2'd2;
    repeat (2) cycle();
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++; if (signal !== 16'h7FFF) begin failures++; $display("FAIL sum_high k=%0d got=%h exp=7fff", k, signal); end
      checks++; if (signal !== m_sig) begin failures++; $display("FAIL sum_high_model k=%0d got=%h exp=%h", k, signal, m_sig); end
    end
    wr(0, 2, 32'h0);
    wr(1, 2, 32'h0);
    commit(0);
    commit(1);
    waited = 0;
    while (pending != 2'b00 && waited < 40) begin
      cycle();
      waited++;
    end
    checks++; if (pending !== 2'b00) begin failures++; $display("FAIL sum_commit_timeout got=%b exp=00", pending); end
    repeat (2) cycle();
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++; if (signal !== 16'h8000) begin failures++; $display("FAIL sum_low k=%0d got=%h exp=8000", k, signal); end
    end
    out_sel = 2'd3;
    cycle();
    checks++; if (signal !== 16'h0) begin failures++; $display("FAIL sum_sel_oob got=%h exp=0000", signal); end
  endtask

  task automatic test_random();
    int addr;
    logic [31:0] data;
    for (int k = 0; k < 1500; k++) begin
      cfg_we = 1'b0;
      cfg_commit = 1'b0;
      cfg_ch = CHW'($urandom_range(0, CH - 1));
      out_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        addr = $urandom_range(0, 7);
        data = $urandom;
        if (addr == 0) data = 32'($urandom_range(0, 15));
        if (addr == 6) data = 32'($urandom_range(0, 4));
        if (addr == 1 && $urandom_range(0, 7) == 0) data = 32'h0;
        cfg_we = 1'b1; cfg_addr = 3'(addr); cfg_wdata = data;
      end
      if ($urandom_range(0, 5) == 0) cfg_commit = 1'b1;
      cycle();
      checks++; if (signal !== m_sig) begin failures++; $display("FAIL rand_signal k=%0d got=%h exp=%h", k, signal, m_sig); end
      checks++; if (pending !== pend_vec()) begin failures++; $display("FAIL rand_pending k=%0d got=%b exp=%b", k, pending, pend_vec()); end
      checks++; if (ch_wrap !== wrap_vec()) begin failures++; $display("FAIL rand_wrap k=%0d got=%b exp=%b", k, ch_wrap, wrap_vec()); end
    end
    cfg_we = 1'b0;
    cfg_commit = 1'b0;
  endtask

  initial begin
    test_reset();
    test_saw();
    test_glitch_free();
    test_pulse();
    test_chirp();
    test_reset_midrun();
    test_sum();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
